// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin shared-bus arbiter with burst limit, tenure timeout and turnaround
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_BURST      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_req,
    output logic [NUM_MASTERS-1:0] m_gnt,
    input  logic                   bus_rd,
    input  logic                   bus_wr,
    input  logic                   bus_ready,
    output logic                   gnt_valid,
    output logic [ID_WIDTH-1:0]    gnt_id,
    output logic                   timeout,
    output logic [15:0]            xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        TURN  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] owner;
    logic [7:0]          tcnt;
    logic [3:0]          burst;
    logic [3:0]          burst_nxt;
    logic [ID_WIDTH-1:0] sel;
    logic                found;
    logic                owner_req;
    logic [ID_WIDTH-1:0] ptr_nxt;
    int                  idx;

    // First requester at or after rr_ptr, wrapping past the top master.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && m_req[idx]) begin
                found = 1'b1;
                sel   = ID_WIDTH'(idx);
            end
        end
    end

    assign owner_req = m_req[owner];
    assign burst_nxt = burst + 4'd1;
    assign ptr_nxt   = (owner == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : owner + ID_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m_gnt      <= '0;
            gnt_valid  <= 1'b0;
            gnt_id     <= '0;
            timeout    <= 1'b0;
            rr_ptr     <= '0;
            owner      <= '0;
            tcnt       <= '0;
            burst      <= '0;
            xfer_count <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= sel;
                        m_gnt     <= NUM_MASTERS'(1) << sel;
                        gnt_valid <= 1'b1;
                        gnt_id    <= sel;
                        tcnt      <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state     <= TURN;
                        m_gnt     <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end else if (bus_rd || bus_wr) begin
                        state <= XFER;
                        tcnt  <= '0;
                    end else if (tcnt == TO_LAST) begin
                        timeout   <= 1'b1;
                        state     <= TURN;
                        m_gnt     <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        burst <= burst_nxt;
                        if (xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
                        // A completion always counts, even when the owner lets go in the same cycle.
                        if (burst_nxt >= BURST_MAX || !owner_req) begin
                            state     <= TURN;
                            m_gnt     <= '0;
                            gnt_valid <= 1'b0;
                            gnt_id    <= '0;
                        end else begin
                            state <= GRANT;
                            tcnt  <= '0;
                        end
                    end else if (!owner_req) begin
                        state     <= TURN;
                        m_gnt     <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end else if (tcnt == TO_LAST) begin
                        timeout   <= 1'b1;
                        state     <= TURN;
                        m_gnt     <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                TURN: begin
                    rr_ptr <= ptr_nxt;
                    burst  <= '0;
                    tcnt   <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;

    logic       clk;
    logic       rst;
    logic [3:0] m_req;
    logic [3:0] m_gnt;
    logic       bus_rd;
    logic       bus_wr;
    logic       bus_ready;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;
    logic [15:0] xfer_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit inv_on   = 0;

    bus_arbiter_rr #(
        .NUM_MASTERS(4), .ID_WIDTH(2), .TIMEOUT_CYCLES(255), .MAX_BURST(2)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_gnt(m_gnt),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout(timeout),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] gnt, input logic [1:0] id);
        chk({tag, "_gnt"}, 32'(m_gnt), 32'(gnt));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(gnt != 4'd0));
        chk({tag, "_id"}, 32'(gnt_id), 32'(id));
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            chk("inv_onehot", 32'($onehot0(m_gnt)), 32'd1);
            chk("inv_valid", 32'(gnt_valid), 32'(|m_gnt));
        end
    end

    initial begin
        logic [3:0] exp_gnt;
        int n;
        rst = 1'b1; m_req = '0; bus_rd = 0; bus_wr = 0; bus_ready = 0;
        step();
        step();
        inv_on = 1;
        chk_grant("reset", 4'b0000, 2'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        chk("reset_xfer", 32'(xfer_count), 32'd0);

        // Two requesters: lowest at/after pointer 0 wins, then master 2 after release.
        rst = 1'b0; m_req = 4'b0110;
        step();
        chk_grant("s1_first", 4'b0010, 2'd1);
        step();
        chk_grant("s1_hold", 4'b0010, 2'd1);
        m_req = 4'b0100;
        step();
        chk_grant("s1_turn", 4'b0000, 2'd0);
        step();
        chk_grant("s1_idle", 4'b0000, 2'd0);
        step();
        chk_grant("s1_next", 4'b0100, 2'd2);
        m_req = 4'b0000;
        step();
        step();

        // All requesting: one read + one completion per tenure, owner drops req with the completion.
        rst = 1'b1;
        step();
        rst = 1'b0; m_req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            chk_grant("s2_grant", exp_gnt, 2'(k % 4));
            bus_rd = 1;
            step();
            chk_grant("s2_xfer", exp_gnt, 2'(k % 4));
            bus_rd = 0; bus_ready = 1; m_req = 4'b1111 & ~exp_gnt;
            step();
            chk_grant("s2_turn", 4'b0000, 2'd0);
            bus_ready = 0; m_req = 4'b1111;
            step();
            chk_grant("s2_idle", 4'b0000, 2'd0);
            step();
        end
        chk_grant("s2_wrap", 4'b0010, 2'd1);
        chk("s2_xfer_count", 32'(xfer_count), 32'd5);
        m_req = 4'b0000;
        step();
        step();

        // Burst limit: master 2 is forced off after its second completion, master 3 follows.
        m_req = 4'b1100;
        step();
        chk_grant("s3_grant", 4'b0100, 2'd2);
        bus_wr = 1;
        step();
        bus_wr = 0; bus_ready = 1;
        step();
        chk_grant("s3_after_ready1", 4'b0100, 2'd2);
        bus_ready = 0; bus_wr = 1;
        step();
        bus_wr = 0; bus_ready = 1;
        step();
        chk_grant("s3_forced_turn", 4'b0000, 2'd0);
        chk("s3_xfer_count", 32'(xfer_count), 32'd7);
        bus_ready = 0;
        step();
        step();
        chk_grant("s3_next", 4'b1000, 2'd3);

        // Reset during XFER drops the grant at that edge; pointer restarts at 0.
        bus_rd = 1;
        step();
        chk_grant("s4_xfer", 4'b1000, 2'd3);
        bus_rd = 0; rst = 1;
        step();
        chk_grant("s4_reset", 4'b0000, 2'd0);
        chk("s4_xfer_count", 32'(xfer_count), 32'd0);
        rst = 0; m_req = 4'b1001;
        step();
        chk_grant("s4_restart", 4'b0001, 2'd0);

        // Timeout: read with no completion for 255 cycles.
        bus_rd = 1;
        step();
        bus_rd = 0;
        n = 0;
        while (timeout !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("s5_timeout_cycles", 32'(n), 32'd255);
        chk_grant("s5_released", 4'b0000, 2'd0);
        chk("s5_xfer_count", 32'(xfer_count), 32'd0);
        step();
        chk("s5_pulse_end", 32'(timeout), 32'd0);
        chk_grant("s5_idle", 4'b0000, 2'd0);
        step();
        chk_grant("s5_ptr_adv", 4'b1000, 2'd3);

        inv_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of bus masters; legal range 2..8.
REQ-002 SHALL have parameter ID_WIDTH, default 2: width of gnt_id; equals ceil(log2(NUM_MASTERS)).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles per tenure phase without progress; legal range 1..255; 8-bit counter.
REQ-004 SHALL have parameter MAX_BURST, default 2: maximum bus_ready completions per tenure; legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 m_req  input  NUM_MASTERS  per-master bus request (each master's m_bus_req).
REQ-008 m_gnt  output  NUM_MASTERS  one-hot grant (each master's m_bus_gnt); registered.
REQ-009 bus_rd  input  1  shared bus read strobe.
REQ-010 bus_wr  input  1  shared bus write strobe.
REQ-011 bus_ready  input  1  memory completion strobe on the shared bus.
REQ-012 gnt_valid  output  1  high whenever any m_gnt bit is high.
REQ-013 gnt_id  output  ID_WIDTH  index of current owner; 0 when gnt_valid is low.
REQ-014 timeout  output  1  one-cycle pulse when a tenure is aborted by timeout.
REQ-015 xfer_count  output  16  count of bus_ready completions since reset; saturates at 16'hFFFF.

Function
REQ-016 SHALL implement states IDLE, GRANT, XFER and TURN; all outputs registered.
REQ-017 IDLE: m_gnt = 0; if m_req != 0, select the first requester at or after rr_ptr, scanning upward and wrapping; assert its m_gnt next cycle; go to GRANT.
REQ-018 Grant latency SHALL be exactly 1 cycle from the first cycle m_req is sampled high in IDLE.
REQ-019 GRANT: owner's m_req low -> TURN; else bus_rd|bus_wr high -> XFER; else stay.
REQ-020 XFER: on bus_ready: increment burst count and xfer_count; burst count reaching MAX_BURST -> TURN; owner's m_req low -> TURN; otherwise -> GRANT.
REQ-021 bus_ready and owner m_req deassertion in the same cycle SHALL count the completion and go to TURN.
REQ-022 Timeout counter SHALL clear on entry to GRANT and XFER, increment each cycle in those states, and on reaching TIMEOUT_CYCLES pulse timeout for 1 cycle and go to TURN.
REQ-023 TURN: m_gnt = 0 for exactly 1 cycle (bus turnaround, no tristate overlap); rr_ptr = owner+1 mod NUM_MASTERS; burst count cleared; go to IDLE.
REQ-024 Requests from non-owners SHALL be ignored during GRANT, XFER and TURN; they are held pending in m_req by the masters.
REQ-025 bus_rd, bus_wr and bus_ready SHALL be ignored in IDLE and TURN.
REQ-026 At most one m_gnt bit SHALL be high in any cycle; the same bit SHALL remain high for the entire tenure.
REQ-027 Minimum spacing between the end of one grant and the start of the next SHALL be 2 cycles (TURN, IDLE).
REQ-028 A master reasserting m_req after a forced release SHALL re-arbitrate normally; it receives no priority boost.

Reset
REQ-029 On rst high at a clock edge: state = IDLE, m_gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0, rr_ptr = 0, burst and timeout counters = 0, xfer_count = 0.
REQ-030 Reset mid-tenure SHALL drop m_gnt at that same edge with no TURN cycle; arbitration restarts from rr_ptr = 0.

Verification
REQ-031 After reset, m_req=4'b0110 -> m_gnt=4'b0010 one cycle later, gnt_id=1; after master 1 releases: one TURN cycle, then m_gnt=4'b0100.
REQ-032 m_req=4'b1111 held, each tenure one bus_rd plus one bus_ready -> grants in order 0,1,2,3,0, each separated by 2 zero-grant cycles; xfer_count=5.
REQ-033 Master 2 holds m_req, asserts bus_wr, bus_ready twice (MAX_BURST=2) -> forced TURN after the second ready; master 3 (requesting) is granted next.
REQ-034 Owner asserts bus_rd, no bus_ready for 255 cycles -> timeout pulses 1 cycle, m_gnt=0 next cycle, rr_ptr advances; xfer_count unchanged.
REQ-035 rst asserted in XFER with m_gnt=4'b1000 -> m_gnt=0 at that edge; after release, m_req=4'b1001 -> master 0 granted.
REQ-036 Every cycle of all scenarios: m_gnt one-hot or zero; gnt_valid == |m_gnt.
